// File: rtl/bias_weight_updater.sv
// Write side of the bias weight table: in-order in-flight queue plus saturating trainer.
// Optional BWU_FORWARD_EN: forward each issued write into matching queued and incoming weights.
module bias_weight_updater #(
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned WEIGHT_W = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [INDEX_W-1:0]       pred_index,
  input  logic [WEIGHT_W-1:0]      pred_weight,
  input  logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     en_1,
  output logic [INDEX_W-1:0]       index_update,
  output logic [WEIGHT_W-1:0]      weight_update,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resolve_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]    FULL_OCC = OCC_W'(DEPTH);
  localparam logic [WEIGHT_W-1:0] W_MAX    = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN    = {1'b1, {(WEIGHT_W-1){1'b0}}};

  logic [INDEX_W-1:0]  r_idx [DEPTH];
  logic [WEIGHT_W-1:0] r_wt  [DEPTH];
  logic                r_tk  [DEPTH];

  logic [PTR_W-1:0]    r_head, r_tail;
  logic [OCC_W-1:0]    r_count;
  logic                r_en;
  logic [INDEX_W-1:0]  r_index_upd;
  logic [WEIGHT_W-1:0] r_weight_upd;
  logic [CNT_W-1:0]    r_mis;
  logic                r_err;

  logic                w_full, w_empty, w_push, w_pop, w_write;
  logic [INDEX_W-1:0]  w_h_idx;
  logic [WEIGHT_W-1:0] w_h_wt, w_new, w_push_wt;
  logic                w_h_tk;

  assign w_full  = (r_count == FULL_OCC);
  assign w_empty = (r_count == '0);
  assign w_push  = pred_valid && !w_full && !flush;
  assign w_pop   = resolve_valid && !w_empty;
  assign w_h_idx = r_idx[r_head];
  assign w_h_wt  = r_wt[r_head];
  assign w_h_tk  = r_tk[r_head];

  always_comb begin
    w_new = w_h_wt;
    if (resolve_taken) begin
      if (w_h_wt != W_MAX) w_new = w_h_wt + WEIGHT_W'(1);
    end else begin
      if (w_h_wt != W_MIN) w_new = w_h_wt - WEIGHT_W'(1);
    end
  end

  assign w_write = w_pop && (w_new != w_h_wt);

  always_comb begin
    w_push_wt = pred_weight;
`ifdef BWU_FORWARD_EN
    if (w_write && (pred_index == w_h_idx)) w_push_wt = w_new;
`endif
  end

  // Payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
`ifdef BWU_FORWARD_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_write && (r_idx[PTR_W'(i)] == w_h_idx)) r_wt[PTR_W'(i)] <= w_new;
    end
`endif
    if (w_push) begin
      r_idx[r_tail] <= pred_index;
      r_wt[r_tail]  <= w_push_wt;
      r_tk[r_tail]  <= pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_en         <= 1'b0;
      r_index_upd  <= '0;
      r_weight_upd <= '0;
      r_mis        <= '0;
      r_err        <= 1'b0;
    end else begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - OCC_W'(1);
      end
      r_en <= w_write;
      if (w_write) begin
        r_index_upd  <= w_h_idx;
        r_weight_upd <= w_new;
      end
      if (w_pop && (w_h_tk != resolve_taken) && (r_mis != '1)) r_mis <= r_mis + CNT_W'(1);
      if (resolve_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign pred_ready     = !w_full;
  assign en_1           = r_en;
  assign index_update   = r_index_upd;
  assign weight_update  = r_weight_upd;
  assign mispredict_cnt = r_mis;
  assign count          = r_count;
  assign resolve_err    = r_err;

endmodule

// File: tb/tb_bias_weight_updater.sv
// Randomized and directed bench for bias_weight_updater against a queue-based reference model.
module tb_bias_weight_updater;

  localparam int INDEX_W  = 10;
  localparam int WEIGHT_W = 2;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 16;
  localparam int W_MAXV   = 2 ** (WEIGHT_W - 1) - 1;
  localparam int W_MINV   = -(2 ** (WEIGHT_W - 1));
  localparam int CNT_MAXV = 2 ** CNT_W - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pred_valid, pred_ready, pred_taken;
  logic [INDEX_W-1:0]      pred_index;
  logic [WEIGHT_W-1:0]     pred_weight;
  logic                    resolve_valid, resolve_taken, flush;
  logic                    en_1;
  logic [INDEX_W-1:0]      index_update;
  logic [WEIGHT_W-1:0]     weight_update;
  logic [CNT_W-1:0]        mispredict_cnt;
  logic [$clog2(DEPTH):0]  count;
  logic                    resolve_err;

  bias_weight_updater #(
    .INDEX_W (INDEX_W),
    .WEIGHT_W(WEIGHT_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_ready    (pred_ready),
    .pred_index    (pred_index),
    .pred_weight   (pred_weight),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .en_1          (en_1),
    .index_update  (index_update),
    .weight_update (weight_update),
    .mispredict_cnt(mispredict_cnt),
    .count         (count),
    .resolve_err   (resolve_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int w;
    bit tk;
  } entry_t;

  entry_t m_q[$];
  bit     m_en;
  int     m_idx, m_wt, m_mis;
  bit     m_err;
  int     n_chk  = 0;
  int     n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int     sz0, nw;
    bit     wr;
    entry_t h, e;
    if (!rst_n) begin
      m_q.delete();
      m_en = 0; m_idx = 0; m_wt = 0; m_mis = 0; m_err = 0;
      return;
    end
    sz0 = m_q.size();
    wr  = 0;
    nw  = 0;
    if (resolve_valid && sz0 == 0) m_err = 1;
    if (resolve_valid && sz0 > 0) begin
      h  = m_q.pop_front();
      nw = resolve_taken ? h.w + 1 : h.w - 1;
      if (nw > W_MAXV) nw = W_MAXV;
      if (nw < W_MINV) nw = W_MINV;
      if (nw != h.w) begin
        wr = 1; m_idx = h.idx; m_wt = nw;
`ifdef BWU_FORWARD_EN
        foreach (m_q[i]) if (m_q[i].idx == h.idx) m_q[i].w = nw;
`endif
      end
      if (h.tk != resolve_taken && m_mis < CNT_MAXV) m_mis++;
    end
    if (pred_valid && sz0 < DEPTH && !flush) begin
      e.idx = int'(pred_index);
      e.w   = int'($signed(pred_weight));
      e.tk  = pred_taken;
`ifdef BWU_FORWARD_EN
      if (wr && e.idx == m_idx) e.w = nw;
`endif
      m_q.push_back(e);
    end
    if (flush) m_q.delete();
    m_en = wr;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".en_1"}, en_1, m_en);
    check({tag, ".count"}, count, m_q.size());
    check({tag, ".ready"}, pred_ready, m_q.size() < DEPTH);
    check({tag, ".mis"}, mispredict_cnt, m_mis);
    check({tag, ".err"}, resolve_err, m_err);
    if (m_en) begin
      check({tag, ".idx"}, index_update, m_idx);
      check({tag, ".wt"}, $signed(weight_update), m_wt);
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit pv, input int idx, input int w, input bit pt,
                       input bit rv, input bit rt, input bit fl);
    pred_valid    = pv;
    pred_index    = INDEX_W'(idx);
    pred_weight   = WEIGHT_W'(w);
    pred_taken    = pt;
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    step("reset");
    check("reset.wt0", weight_update, 0);
    check("reset.idx0", index_update, 0);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(negedge clk);
    do_reset();

    // Basic train to +1.
    drive(1, 'h05, 0, 1, 0, 0, 0); step("t1.push");
    drive(0, 0, 0, 0, 1, 1, 0);    step("t1.res");
    check("t1.en", en_1, 1);
    check("t1.idx", index_update, 'h005);
    check("t1.wt", weight_update, 2'b01);
    idle(); step("t1.idle");
    check("t1.en_fall", en_1, 0);

    // Saturated top, then trained up from -2 with a mispredict.
    drive(1, 'h3FF, 1, 1, 0, 0, 0); step("t2.push");
    drive(0, 0, 0, 0, 1, 1, 0);     step("t2.res");
    check("t2.sat_en", en_1, 0);
    drive(1, 'h3FF, -2, 0, 0, 0, 0); step("t2.push2");
    drive(0, 0, 0, 0, 1, 1, 0);      step("t2.res2");
    check("t2.wt", weight_update, 2'b11);
    check("t2.mis", mispredict_cnt, 1);

    // Fill, overflow, then simultaneous push/pop at count=4.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 'h100 + i, (i % 4) - 2, i[0], 0, 0, 0); step("t3.fill");
    end
    check("t3.full_ready", pred_ready, 0);
    check("t3.full_cnt", count, DEPTH);
    drive(1, 'h1FF, 0, 0, 0, 0, 0); step("t3.ovf");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 1, 0); step("t3.drain");
    end
    drive(1, 'h155, 0, 1, 1, 0, 0); step("t3.pushpop");
    check("t3.cnt4", count, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0); step("t3.fifo");
    end
    idle(); step("t3.idle");

    // Flush together with resolve writes the head first.
    for (int i = 0; i < 3; i++) begin
      drive(1, 'h20 + i, 0, 1, 0, 0, 0); step("t4.push");
    end
    drive(0, 0, 0, 0, 1, 1, 1); step("t4.flush");
    check("t4.en", en_1, 1);
    check("t4.idx", index_update, 'h20);
    check("t4.cnt", count, 0);
    drive(0, 0, 0, 0, 1, 1, 0); step("t4.late");
    check("t4.err", resolve_err, 1);
    do_reset();

    // Same index back to back: forwarding decides the second write.
    drive(1, 'h10, 0, 1, 0, 0, 0); step("t5.p0");
    drive(1, 'h10, 0, 1, 0, 0, 0); step("t5.p1");
    drive(0, 0, 0, 0, 1, 1, 0);    step("t5.r0");
    check("t5.wt0", weight_update, 2'b01);
    drive(0, 0, 0, 0, 1, 1, 0);    step("t5.r1");
`ifdef BWU_FORWARD_EN
    check("t5.en1", en_1, 0);
`else
    check("t5.en1", en_1, 1);
    check("t5.wt1", weight_update, 2'b01);
`endif

    // Reset mid-stream with queued entries.
    drive(0, 0, 0, 0, 1, 0, 0); step("t6.mis");
    for (int i = 0; i < 5; i++) begin
      drive(1, 'h40 + i, 1, 0, 0, 0, 0); step("t6.push");
    end
    drive(0, 0, 0, 0, 1, 1, 0);
    rst_n = 0; step("t6.rst");
    check("t6.cnt", count, 0);
    check("t6.en", en_1, 0);
    check("t6.mis", mispredict_cnt, 0);
    rst_n = 1;

    // Random traffic over a small index set to exercise collisions.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 9) < 4, $urandom_range(0, 1),
            $urandom_range(0, 39) == 0);
      step("rnd");
    end
    rst_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bias_weight_updater.md
Name: bias_weight_updater

Overview:
- Write-side counterpart of the bias weight table in the bias-free neural predictor.
- Captures each prediction's table index, read weight and predicted direction into an in-order in-flight queue.
- On branch resolution, computes the trained weight and issues a single-cycle write (en_1 / index_update / weight_update).
- The table commits the write on the following negedge.

Parameters:
INDEX_W, 10, width of table index
WEIGHT_W, 2, width of a bias weight (two's complement; range -2..+1 at default)
DEPTH, 8, in-flight queue entries (power of two)
CNT_W, 16, width of misprediction counter

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
pred_valid  in  1  prediction issued this cycle
pred_ready  out  1  queue can accept; equals !full
pred_index  in  INDEX_W  table index used for prediction
pred_weight  in  WEIGHT_W  weight read from table
pred_taken  in  1  predicted direction
resolve_valid  in  1  oldest in-flight branch resolved
resolve_taken  in  1  actual direction
flush  in  1  discard all in-flight entries
en_1  out  1  table write enable
index_update  out  INDEX_W  table write index
weight_update  out  WEIGHT_W  table write data
mispredict_cnt  out  CNT_W  saturating count of mispredictions
count  out  $clog2(DEPTH)+1  queue occupancy
resolve_err  out  1  sticky: resolve seen with queue empty

Behaviour:
- Reset (rst_n=0 at posedge):
  - Queue empty; count=0; pred_ready=1; en_1=0; index_update=0; weight_update=0; mispredict_cnt=0; resolve_err=0.
  - Reset mid-operation discards all entries; no write is issued.
- Push: pred_valid && pred_ready enqueues {pred_index, pred_weight, pred_taken} at the tail. pred_valid while full is ignored; no overwrite.
- Pop: resolve_valid with count>0 dequeues the head. In the same posedge:
  - w_new = resolve_taken ? sat(w+1) : sat(w-1), clamped to [-2^(WEIGHT_W-1), 2^(WEIGHT_W-1)-1].
  - If w_new != w: en_1=1, index_update=head.index, weight_update=w_new. Otherwise en_1=0 (saturated, no write).
  - If head.pred_taken != resolve_taken: mispredict_cnt increments, holding at all-ones.
- Latency:
  - en_1 is registered, high exactly one cycle, in the cycle after the resolve posedge.
  - Outputs are stable across the following negedge, where the table writes.
  - At most one write per cycle.
- Resolve with empty queue: ignored; resolve_err set, held until reset.
- Simultaneous push and pop: both performed; count unchanged. When full, push is still refused (pred_ready is !full, no same-cycle bypass).
- Flush:
  - Queue cleared at posedge; count=0.
  - If resolve_valid is in the same cycle, the head is resolved and written first, then the remainder is discarded.
  - A push in the same cycle as flush is dropped.
- Pointers: wrap modulo DEPTH; full/empty derived from count.
- en_1 falls to 0 in any cycle without a qualifying pop.

Optional Feature:
BWU_FORWARD_EN
- Defined: when a write is issued, every still-queued entry with index == index_update has its stored weight replaced by weight_update in the same posedge. A push in that cycle whose pred_index matches is also captured with weight_update instead of pred_weight. Later resolves then train from current values.
- Undefined: queued weights are never modified; back-to-back branches to the same index train from the stale read value (last write wins).

Test Plan:
1. Reset, then push idx=0x05 w=0 taken=1; resolve taken=1 -> next cycle en_1=1, index_update=0x005, weight_update=+1 (01); mispredict_cnt=0.
2. Push idx=0x3FF w=+1 taken=1; resolve taken=1 -> en_1=0 (saturated); then push w=-2 taken=0, resolve taken=1 -> en_1=1, weight_update=-1 (11), mispredict_cnt=1.
3. Push 8 entries without resolve -> pred_ready=0, count=8; 9th pred_valid ignored. Push and resolve in the same cycle at count=4 -> count stays 4; entries retire in FIFO order.
4. Push 3 entries; assert flush together with resolve -> the first entry is written, count=0 next cycle, and later resolves set resolve_err=1.
5. With BWU_FORWARD_EN: push idx=0x10 w=0 twice; resolve taken=1 twice -> writes +1 then stays +1 (en_1=0 second time). Without the macro -> both writes carry +1 (both en_1=1).
6. Assert rst_n=0 mid-stream with 5 queued entries -> the next cycle shows count=0, en_1=0, mispredict_cnt=0.
